token_uart_tx: RTL and testbench

Downstream framer and serial transmitter for the tokenised PAN. It captures the 8-byte token burst that the validator top streams out one byte per cycle, together with the Luhn and IIN-hit flags, and double-buffers it. It then transmits the token as a framed 8N1 UART packet on a single pin. The packet is SYNC, STATUS, eight token bytes and an optional CRC-8. This block is the external-facing output stage of the card pipeline.

---
 rtl/token_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_token_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_uart_tx.sv
// Token framer and 8N1 UART transmitter: captures an 8-byte token burst, double-buffers it
// and sends SYNC, STATUS, token bytes and (with TOKEN_TX_CRC_EN defined) a trailing CRC-8.
module token_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [2:0] tok_idx,
  input  logic [7:0] tok_byte,
  input  logic       luhn_valid,
  input  logic       meta_hit,
  input  logic       clr_err,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       seq_err
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
`ifdef TOKEN_TX_CRC_EN
  localparam logic [3:0]  LAST_PTR  = 4'd10;
`else
  localparam logic [3:0]  LAST_PTR  = 4'd9;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

`ifdef TOKEN_TX_CRC_EN
  // One byte of CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Capture buffer
  logic        cap_open_q, cap_open_d;
  logic        cap_full_q, cap_full_d;
  logic        drop_q, drop_d;
  logic [2:0]  exp_idx_q, exp_idx_d;
  logic [63:0] cap_data_q, cap_data_d;
  logic [7:0]  cap_status_q, cap_status_d;

  // Transmit buffer
  logic        txb_valid_q, txb_valid_d;
  logic [63:0] txb_data_q, txb_data_d;
  logic [7:0]  txb_status_q, txb_status_d;

`ifdef TOKEN_TX_CRC_EN
  logic [7:0]  cap_crc_q, cap_crc_d;
  logic [7:0]  txb_crc_q, txb_crc_d;
`endif

  // Transmitter
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        uart_tx_q, uart_tx_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;
  logic        seq_err_q, seq_err_d;

  logic        bit_end;
  logic        release_txb;
  logic        load_txb;
  logic        start_cap;
  logic        ovr_set;
  logic [7:0]  new_status;
  logic [2:0]  tok_sel;
  logic [7:0]  frame_byte;

  assign bit_end     = (baud_q == BAUD_MAX);
  assign release_txb = (state_q == STOP) && bit_end && (ptr_q == LAST_PTR);
  // CAP moves to TXB when TXB is empty or is being freed by the final stop bit.
  assign load_txb    = cap_full_q && (!txb_valid_q || release_txb);
  assign new_status  = {luhn_valid, meta_hit, 6'b0};

  always_comb begin
    cap_open_d   = cap_open_q;
    cap_full_d   = cap_full_q;
    drop_d       = drop_q;
    exp_idx_d    = exp_idx_q;
    cap_data_d   = cap_data_q;
    cap_status_d = cap_status_q;
`ifdef TOKEN_TX_CRC_EN
    cap_crc_d    = cap_crc_q;
`endif
    seq_err_d    = 1'b0;
    ovr_set      = 1'b0;
    start_cap    = 1'b0;

    if (load_txb) begin
      cap_full_d = 1'b0;
    end

    if (cap_open_q) begin
      if (tok_valid && (tok_idx == exp_idx_q)) begin
        cap_data_d[{tok_idx, 3'b000} +: 8] = tok_byte;
`ifdef TOKEN_TX_CRC_EN
        cap_crc_d = crc8_byte(cap_crc_q, tok_byte);
`endif
        if (exp_idx_q == 3'd7) begin
          cap_open_d = 1'b0;
          cap_full_d = 1'b1;
        end else begin
          exp_idx_d = exp_idx_q + 3'd1;
        end
      end else begin
        seq_err_d  = 1'b1;
        cap_open_d = 1'b0;
        start_cap  = tok_valid && (tok_idx == 3'd0);
      end
    end else if (tok_valid) begin
      if (tok_idx == 3'd0) begin
        if (cap_full_q && !load_txb) begin
          ovr_set = 1'b1;
          drop_d  = 1'b1;
        end else begin
          start_cap = 1'b1;
        end
      end else if (!drop_q) begin
        seq_err_d = 1'b1;
      end
    end

    // A dropped burst stays silently ignored until its strobe falls.
    if (!tok_valid) begin
      drop_d = 1'b0;
    end

    if (start_cap) begin
      cap_open_d       = 1'b1;
      drop_d           = 1'b0;
      exp_idx_d        = 3'd1;
      cap_data_d[7:0]  = tok_byte;
      cap_status_d     = new_status;
`ifdef TOKEN_TX_CRC_EN
      cap_crc_d        = crc8_byte(crc8_byte(8'h00, new_status), tok_byte);
`endif
    end
  end

  always_comb begin
    txb_data_d   = txb_data_q;
    txb_status_d = txb_status_q;
`ifdef TOKEN_TX_CRC_EN
    txb_crc_d    = txb_crc_q;
`endif
    txb_valid_d  = txb_valid_q;
    if (load_txb) begin
      txb_valid_d  = 1'b1;
      txb_data_d   = cap_data_q;
      txb_status_d = cap_status_q;
`ifdef TOKEN_TX_CRC_EN
      txb_crc_d    = cap_crc_q;
`endif
    end else if (release_txb) begin
      txb_valid_d = 1'b0;
    end
    overrun_d = ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  always_comb begin
    tok_sel    = 3'(ptr_q - 4'd2);
    frame_byte = 8'hFF;
    if (ptr_q == 4'd0) begin
      frame_byte = SYNC_BYTE;
    end else if (ptr_q == 4'd1) begin
      frame_byte = txb_status_q;
    end else if (ptr_q <= 4'd9) begin
      frame_byte = txb_data_q[{tok_sel, 3'b000} +: 8];
    end
`ifdef TOKEN_TX_CRC_EN
    else if (ptr_q == 4'd10) begin
      frame_byte = txb_crc_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    baud_d       = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_d        = bit_q;
    ptr_d        = ptr_q;
    frame_done_d = release_txb;
    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (txb_valid_q || load_txb) begin
          state_d = START;
          ptr_d   = 4'd0;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (ptr_q == LAST_PTR) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            ptr_d   = ptr_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so it is derived from the next state.
    unique case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = frame_byte[bit_d];
      default: uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_open_q   <= 1'b0;
      cap_full_q   <= 1'b0;
      drop_q       <= 1'b0;
      exp_idx_q    <= 3'd0;
      cap_data_q   <= 64'd0;
      cap_status_q <= 8'd0;
      txb_valid_q  <= 1'b0;
      txb_data_q   <= 64'd0;
      txb_status_q <= 8'd0;
`ifdef TOKEN_TX_CRC_EN
      cap_crc_q    <= 8'd0;
      txb_crc_q    <= 8'd0;
`endif
      state_q      <= IDLE;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      ptr_q        <= 4'd0;
      uart_tx_q    <= 1'b1;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      cap_open_q   <= cap_open_d;
      cap_full_q   <= cap_full_d;
      drop_q       <= drop_d;
      exp_idx_q    <= exp_idx_d;
      cap_data_q   <= cap_data_d;
      cap_status_q <= cap_status_d;
      txb_valid_q  <= txb_valid_d;
      txb_data_q   <= txb_data_d;
      txb_status_q <= txb_status_d;
`ifdef TOKEN_TX_CRC_EN
      cap_crc_q    <= cap_crc_d;
      txb_crc_q    <= txb_crc_d;
`endif
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      ptr_q        <= ptr_d;
      uart_tx_q    <= uart_tx_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign uart_tx    = uart_tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_token_uart_tx.sv
// Directed self-checking bench for token_uart_tx: a UART receiver model collects the
// serial bytes and frames are compared against hand-computed bytes and CRCs.
module tb_token_uart_tx;

  localparam int CPB = 16;
`ifdef TOKEN_TX_CRC_EN
  localparam int FRAME_BYTES = 11;
`else
  localparam int FRAME_BYTES = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BYTES * 10 * CPB;

  logic       clk;
  logic       rst;
  logic       tok_valid;
  logic [2:0] tok_idx;
  logic [7:0] tok_byte;
  logic       luhn_valid;
  logic       meta_hit;
  logic       clr_err;
  logic       uart_tx;
  logic       tx_busy;
  logic       frame_done;
  logic       overrun;
  logic       seq_err;

  int total = 0;
  int bad = 0;
  int seqErrCnt = 0;
  int frameDoneCnt = 0;
  logic [7:0] rxQ [$];

  token_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tok_valid  (tok_valid),
    .tok_idx    (tok_idx),
    .tok_byte   (tok_byte),
    .luhn_valid (luhn_valid),
    .meta_hit   (meta_hit),
    .clr_err    (clr_err),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (seq_err === 1'b1) seqErrCnt <= seqErrCnt + 1;
    if (frame_done === 1'b1) frameDoneCnt <= frameDoneCnt + 1;
  end

  // Receiver model: samples each bit in its middle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (CPB / 2) @(posedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(posedge clk);
        rxQ.push_back(b);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] tok, input logic luhn, input logic meta,
                               input logic clrFirst);
    for (int i = 0; i < 8; i++) begin
      tok_valid  = 1'b1;
      tok_idx    = 3'(i);
      tok_byte   = tok[8*i +: 8];
      luhn_valid = (i == 0) ? luhn : 1'b0;
      meta_hit   = (i == 0) ? meta : 1'b0;
      clr_err    = (i == 0) ? clrFirst : 1'b0;
      @(posedge clk);
      #1;
    end
    tok_valid  = 1'b0;
    tok_idx    = 3'd0;
    tok_byte   = 8'd0;
    luhn_valid = 1'b0;
    meta_hit   = 1'b0;
    clr_err    = 1'b0;
  endtask

  task automatic waitFrameDone(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (frame_done !== 1'b1 && n < 4000);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] status, input logic [63:0] tok,
                            input logic [7:0] crc);
    logic [7:0]  exp [11];
    logic [31:0] obs;
    exp[0] = 8'hA5;
    exp[1] = status;
    for (int i = 0; i < 8; i++) exp[2+i] = tok[8*i +: 8];
    exp[10] = crc;
    checkOutput({tag, " len"}, rxQ.size(), FRAME_BYTES);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (rxQ.size() > 0) obs = {24'd0, rxQ.pop_front()};
      else obs = 32'hDEAD;
      checkOutput($sformatf("%s b%0d", tag, i), obs, {24'd0, exp[i]});
    end
  endtask

  initial begin
    int n;
    int seqBase;
    int doneBase;
    rst = 1'b1; tok_valid = 1'b0; tok_idx = 3'd0; tok_byte = 8'd0;
    luhn_valid = 1'b0; meta_hit = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst uart_tx", uart_tx, 1);
    checkOutput("rst tx_busy", tx_busy, 0);
    checkOutput("rst frame_done", frame_done, 0);
    checkOutput("rst overrun", overrun, 0);
    checkOutput("rst seq_err", seq_err, 0);
    repeat (2) @(posedge clk);
    #1;

    // Basic frame: zero status, token 00x7 then 01, CRC 07.
    applyStimulus(64'h01000000_00000000, 1'b0, 1'b0, 1'b0);
    checkOutput("basic idle at E", uart_tx, 1);
    @(posedge clk);
    #1;
    checkOutput("basic start E+1", uart_tx, 0);
    checkOutput("basic busy E+1", tx_busy, 1);
    waitFrameDone(n);
    checkOutput("basic frame cycles", n, FRAME_CYCLES);
    checkOutput("basic busy end", tx_busy, 0);
    checkFrame("basic", 8'h00, 64'h01000000_00000000, 8'h07);
    repeat (5) @(posedge clk);
    #1;

    // Status capture: C0 then 4E zeroes the CRC, so it ends at 07 again.
    applyStimulus(64'h01000000_0000004E, 1'b1, 1'b1, 1'b0);
    waitFrameDone(n);
    checkOutput("status frame cycles", n, FRAME_CYCLES + 1);
    checkFrame("status", 8'hC0, 64'h01000000_0000004E, 8'h07);
    repeat (5) @(posedge clk);
    #1;

    // Double buffering and overrun (clr_err coincides with the overrun: set wins).
    seqBase = seqErrCnt;
    applyStimulus(64'h01000000_00000000, 1'b0, 1'b0, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    applyStimulus(64'h02000000_00000089, 1'b1, 1'b0, 1'b0);
    checkOutput("dbuf busy", tx_busy, 1);
    checkOutput("dbuf no overrun", overrun, 0);
    repeat (50) @(posedge clk);
    #1;
    applyStimulus(64'h55555555_55555555, 1'b0, 1'b1, 1'b1);
    checkOutput("dbuf overrun set", overrun, 1);
    checkOutput("dbuf no seq_err", seqErrCnt - seqBase, 0);
    waitFrameDone(n);
    checkOutput("dbuf gap line", uart_tx, 1);
    checkOutput("dbuf gap busy", tx_busy, 0);
    @(posedge clk);
    #1;
    checkOutput("dbuf f2 start", uart_tx, 0);
    checkOutput("dbuf f2 busy", tx_busy, 1);
    checkFrame("dbuf f1", 8'h00, 64'h01000000_00000000, 8'h07);
    waitFrameDone(n);
    checkOutput("dbuf f2 cycles", n, FRAME_CYCLES);
    checkFrame("dbuf f2", 8'h80, 64'h02000000_00000089, 8'h0E);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("dbuf no third frame", rxQ.size(), 0);
    checkOutput("dbuf idle", tx_busy, 0);
    checkOutput("dbuf overrun held", overrun, 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checkOutput("dbuf overrun clr", overrun, 0);

    // Sequence error: idx 0,1,2,4.
    seqBase  = seqErrCnt;
    doneBase = frameDoneCnt;
    tok_valid = 1'b1; tok_idx = 3'd0; tok_byte = 8'h11;
    @(posedge clk); #1;
    tok_idx = 3'd1; tok_byte = 8'h22;
    @(posedge clk); #1;
    tok_idx = 3'd2; tok_byte = 8'h33;
    @(posedge clk); #1;
    checkOutput("seq no early pulse", seq_err, 0);
    tok_idx = 3'd4; tok_byte = 8'h44;
    @(posedge clk); #1;
    tok_valid = 1'b0; tok_idx = 3'd0; tok_byte = 8'd0;
    checkOutput("seq pulse", seq_err, 1);
    @(posedge clk); #1;
    checkOutput("seq pulse end", seq_err, 0);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("seq count", seqErrCnt - seqBase, 1);
    checkOutput("seq no done", frameDoneCnt - doneBase, 0);
    checkOutput("seq busy", tx_busy, 0);
    checkOutput("seq no bytes", rxQ.size(), 0);
    applyStimulus(64'h01000000_000000C7, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("seq clean start", uart_tx, 0);
    waitFrameDone(n);
    checkOutput("seq clean cycles", n, FRAME_CYCLES);
    checkFrame("seq clean", 8'h40, 64'h01000000_000000C7, 8'h07);
    repeat (5) @(posedge clk);
    #1;

    // Reset during DATA of frame byte 3.
    applyStimulus(64'h01000000_00000000, 1'b0, 1'b0, 1'b0);
    repeat (1 + 3 * 10 * CPB + CPB + 40) @(posedge clk);
    #1;
    checkOutput("rstmid busy before", tx_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstmid uart_tx", uart_tx, 1);
    checkOutput("rstmid tx_busy", tx_busy, 0);
    doneBase = frameDoneCnt;
    repeat (2000) @(posedge clk);
    #1;
    checkOutput("rstmid no done", frameDoneCnt - doneBase, 0);
    checkOutput("rstmid idle", tx_busy, 0);
    rxQ.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
